// File: rtl/spw_rx_pkg.sv
// Shared types, default constants and a width helper for the SpaceWire
// receive-activity monitor.
package spw_rx_pkg;

    // Link-monitor states
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_DISC   = 2'd2
    } spw_rx_state_e;

    // Stretch length of the activity level, in clk cycles
    localparam int HOLD_CYCLES_DEF = 1024;
    // Silent gap that declares a disconnect (850 ns at 100 MHz)
    localparam int DISC_CYCLES_DEF = 85;

    // Bits needed to hold 0..max_val; never narrower than one bit
    function automatic int cnt_width(input int max_val);
        return (max_val < 2) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/spw_sync_bit.sv
// Multi-flop synchronizer for one asynchronous SpaceWire line.
// Synchronous active-high reset clears the whole chain.
module spw_sync_bit #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] sync_q;
    logic [STAGES-1:0] sync_d;

    // Shift the raw line one stage deeper every cycle
    always_comb begin
        sync_d = {sync_q[STAGES-2:0], d};
    end

    // Synchronizer chain flops
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q <= '0;
        end else begin
            sync_q <= sync_d;
        end
    end

    assign q = sync_q[STAGES-1];

endmodule

// File: rtl/spw_rx_activity_monitor.sv
// SpaceWire receive-activity monitor.
// Synchronizes the raw data/strobe pair, detects transitions of D^S,
// stretches them into a level for the PIO in_port and flags a link
// disconnect after a silent gap. The optional saturating edge counter
// is built only when SPW_RX_ACT_EDGE_COUNT_EN is defined.
module spw_rx_activity_monitor
    import spw_rx_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int HOLD_CYCLES = HOLD_CYCLES_DEF,
    parameter int DISC_CYCLES = DISC_CYCLES_DEF,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             spw_din,
    input  logic             spw_sin,
    input  logic             clear_i,
    output logic             activity_o,
    output logic             first_edge_o,
    output logic             disconnect_o
`ifdef SPW_RX_ACT_EDGE_COUNT_EN
    ,
    output logic [CNT_W-1:0] edge_count_o
`endif
);

    localparam int WU_MAX = SYNC_STAGES + 1;
    localparam int WU_W   = cnt_width(WU_MAX);
    localparam int HOLD_W = cnt_width(HOLD_CYCLES - 1);
    localparam int GAP_W  = cnt_width(DISC_CYCLES);

    localparam logic [WU_W-1:0]   WU_LAST   = WU_W'(WU_MAX);
    localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(HOLD_CYCLES - 1);
    localparam logic [GAP_W-1:0]  GAP_MAX   = GAP_W'(DISC_CYCLES);

    // Reject out-of-range parameters at elaboration
    if (SYNC_STAGES < 2 || SYNC_STAGES > 4 || HOLD_CYCLES < 1 ||
        DISC_CYCLES < 2 || CNT_W < 1) begin : g_param_check
        $error("spw_rx_activity_monitor: illegal parameter value");
    end

    logic                din_s;
    logic                sin_s;
    logic                ds;

    logic                ds_prev_q, ds_prev_d;
    logic                edge_q, edge_d;
    logic [WU_W-1:0]     wu_q, wu_d;
    logic [HOLD_W-1:0]   hold_q, hold_d;
    logic [GAP_W-1:0]    gap_q, gap_d;
    spw_rx_state_e       state_q, state_d;
    logic                act_q, act_d;
    logic                first_q, first_d;
    logic                disc_q, disc_d;

    spw_sync_bit #(.STAGES(SYNC_STAGES)) u_sync_din (
        .clk   (clk),
        .reset (reset),
        .d     (spw_din),
        .q     (din_s)
    );

    spw_sync_bit #(.STAGES(SYNC_STAGES)) u_sync_sin (
        .clk   (clk),
        .reset (reset),
        .d     (spw_sin),
        .q     (sin_s)
    );

    // Every data or strobe transition toggles D^S exactly once
    assign ds = din_s ^ sin_s;

    // Edge detect on D^S; muted until the chains hold only post-reset samples
    // so a line that is static but non-zero at reset release is not an edge
    always_comb begin
        ds_prev_d = ds;
        wu_d      = (wu_q == WU_LAST) ? wu_q : wu_q + WU_W'(1);
        edge_d    = (ds != ds_prev_q) && (wu_q == WU_LAST);
    end

    // Activity stretcher: reload on each edge, run down to 0 and stop;
    // the level stays up while the count is non-zero plus the edge cycle
    always_comb begin
        hold_d = hold_q;
        if (edge_q) begin
            hold_d = HOLD_LOAD;
        end else if (hold_q != '0) begin
            hold_d = hold_q - HOLD_W'(1);
        end
        act_d = edge_q || (hold_q != '0);
    end

    // Silent-gap counter and link-state machine
    always_comb begin
        gap_d = gap_q;
        if (edge_q) begin
            gap_d = '0;
        end else if (state_q == ST_ACTIVE && gap_q != GAP_MAX) begin
            gap_d = gap_q + GAP_W'(1);
        end

        state_d = state_q;
        first_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (edge_q) begin
                    state_d = ST_ACTIVE;
                    first_d = 1'b1;
                end
            end
            ST_ACTIVE: begin
                // Gap reaching the limit this cycle moves straight to DISC
                if (gap_d == GAP_MAX) begin
                    state_d = ST_DISC;
                end
            end
            ST_DISC: begin
                // Only clear_i leaves; an edge in the same cycle re-links at once
                if (clear_i) begin
                    if (edge_q) begin
                        state_d = ST_ACTIVE;
                        first_d = 1'b1;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        disc_d = (state_d == ST_DISC);
    end

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (reset) begin
            ds_prev_q <= 1'b0;
            edge_q    <= 1'b0;
            wu_q      <= '0;
            hold_q    <= '0;
            gap_q     <= '0;
            state_q   <= ST_IDLE;
            act_q     <= 1'b0;
            first_q   <= 1'b0;
            disc_q    <= 1'b0;
        end else begin
            ds_prev_q <= ds_prev_d;
            edge_q    <= edge_d;
            wu_q      <= wu_d;
            hold_q    <= hold_d;
            gap_q     <= gap_d;
            state_q   <= state_d;
            act_q     <= act_d;
            first_q   <= first_d;
            disc_q    <= disc_d;
        end
    end

    assign activity_o   = act_q;
    assign first_edge_o = first_q;
    assign disconnect_o = disc_q;

`ifdef SPW_RX_ACT_EDGE_COUNT_EN
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Saturating edge count; clear wins but still counts a coincident edge
    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = edge_q ? CNT_W'(1) : '0;
        end else if (edge_q && cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Edge counter register
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign edge_count_o = cnt_q;
`endif

endmodule

// File: tb/tb_spw_rx_activity_monitor.sv
// Self-checking bench for spw_rx_activity_monitor.
// The reference model works on time stamps: a line change sampled at
// posedge p takes effect on the outputs at posedge p+SYNC_STAGES+1, the
// activity level is "less than HOLD cycles since the last effective edge"
// and a disconnect is "DISC cycles since the last edge while linked".
module tb_spw_rx_activity_monitor;

    localparam int SS   = 2;
    localparam int HOLD = 1024;
    localparam int DISC = 85;
    localparam int CW   = 9;
    localparam int CMAX = (1 << CW) - 1;

    localparam int M_IDLE = 0;
    localparam int M_LINK = 1;
    localparam int M_DISC = 2;

    logic clk     = 1'b0;
    logic reset   = 1'b1;
    logic spw_din = 1'b0;
    logic spw_sin = 1'b0;
    logic clear_i = 1'b0;
    logic activity_o;
    logic first_edge_o;
    logic disconnect_o;
`ifdef SPW_RX_ACT_EDGE_COUNT_EN
    logic [CW-1:0] edge_count_o;
`endif

    spw_rx_activity_monitor #(
        .SYNC_STAGES (SS),
        .HOLD_CYCLES (HOLD),
        .DISC_CYCLES (DISC),
        .CNT_W       (CW)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .spw_din      (spw_din),
        .spw_sin      (spw_sin),
        .clear_i      (clear_i),
        .activity_o   (activity_o),
        .first_edge_o (first_edge_o),
        .disconnect_o (disconnect_o)
`ifdef SPW_RX_ACT_EDGE_COUNT_EN
        ,
        .edge_count_o (edge_count_o)
`endif
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // model state
    int cyc      = 0;
    int pend[$];
    bit prev_ok  = 1'b0;
    bit prev_ds  = 1'b0;
    int last_eff = -1;
    int st       = M_IDLE;
    bit m_act    = 1'b0;
    bit m_first  = 1'b0;
    bit m_disc   = 1'b0;
    int m_cnt    = 0;

    bit cur_d = 1'b0;
    bit cur_s = 1'b0;

    task automatic chk(input string tag, input int got, input int exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, want %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Advance the model by one posedge with the inputs sampled there
    task automatic mdl(input bit d, input bit s, input bit r, input bit c);
        bit e;
        bit ds;
        cyc++;
        if (r) begin
            pend.delete();
            prev_ok  = 1'b0;
            last_eff = -1;
            st       = M_IDLE;
            m_act    = 1'b0;
            m_first  = 1'b0;
            m_disc   = 1'b0;
            m_cnt    = 0;
            return;
        end
        e = 1'b0;
        if (pend.size() > 0 && pend[0] == cyc) begin
            e = 1'b1;
            void'(pend.pop_front());
        end
        ds = d ^ s;
        if (prev_ok && ds != prev_ds) pend.push_back(cyc + SS + 1);
        prev_ds = ds;
        prev_ok = 1'b1;

        m_first = e && (st == M_IDLE || (st == M_DISC && c));
        if (e) last_eff = cyc;
        case (st)
            M_IDLE: if (e) st = M_LINK;
            M_LINK: if (!e && cyc - last_eff >= DISC) st = M_DISC;
            default: if (c) st = e ? M_LINK : M_IDLE;
        endcase
        m_disc = (st == M_DISC);
        m_act  = (last_eff >= 0) && (cyc - last_eff < HOLD);
        if (c) m_cnt = e ? 1 : 0;
        else if (e && m_cnt < CMAX) m_cnt++;
    endtask

    // Drive one cycle of inputs at the negedge, check outputs at the next negedge
    task automatic step(input bit d, input bit s, input bit r, input bit c);
        spw_din = d;
        spw_sin = s;
        reset   = r;
        clear_i = c;
        mdl(d, s, r, c);
        @(posedge clk);
        @(negedge clk);
        chk("act", activity_o, m_act);
        chk("first", first_edge_o, m_first);
        chk("disc", disconnect_o, m_disc);
`ifdef SPW_RX_ACT_EDGE_COUNT_EN
        chk("cnt", edge_count_o, m_cnt);
`endif
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(cur_d, cur_s, 1'b0, 1'b0);
    endtask

    task automatic tog_step(input int which, input bit c);
        if (which == 0) cur_d = ~cur_d;
        else            cur_s = ~cur_s;
        step(cur_d, cur_s, 1'b0, c);
    endtask

    // One din toggle, then watch the outputs for win cycles; offsets are
    // counted from the last posedge before the toggle was driven
    task automatic shot(input int win, output int fe_at, output int fe_n,
                        output int act_n, output int dc_at);
        int t0;
        t0 = cyc;
        fe_at = -1; fe_n = 0; act_n = 0; dc_at = -1;
        for (int i = 0; i < win; i++) begin
            if (i == 0) tog_step(0, 1'b0);
            else        idle(1);
            if (first_edge_o) begin
                fe_n++;
                if (fe_at < 0) fe_at = cyc - t0;
            end
            if (activity_o) act_n++;
            if (disconnect_o && dc_at < 0) dc_at = cyc - t0;
        end
    endtask

    initial begin
        int fe_at, fe_n, act_n, dc_at;
        int act_lo, disc_n;

        // reset values
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b1, 1'b0);
        chk("rst_act", activity_o, 0);
        chk("rst_first", first_edge_o, 0);
        chk("rst_disc", disconnect_o, 0);

        // static non-zero D^S straight out of reset must not look like an edge
        cur_d = 1'b1; cur_s = 1'b0;
        fe_n = 0; act_n = 0; disc_n = 0;
        for (int i = 0; i < 100; i++) begin
            idle(1);
            fe_n   += int'(first_edge_o);
            act_n  += int'(activity_o);
            disc_n += int'(disconnect_o);
        end
        chk("wu_first", fe_n, 0);
        chk("wu_act", act_n, 0);
        chk("wu_disc", disc_n, 0);

        // isolated toggle: pulse latency, stretch length, disconnect time
        shot(1200, fe_at, fe_n, act_n, dc_at);
        chk("one_fe_lat", fe_at, SS + 2);
        chk("one_fe_len", fe_n, 1);
        chk("one_act_len", act_n, HOLD);
        chk("one_dc_lat", dc_at, SS + 2 + DISC);

        // clear from disconnect without an edge, then clear coincident with an edge
        step(cur_d, cur_s, 1'b0, 1'b1);
        chk("clr_disc", disconnect_o, 0);
        tog_step(1, 1'b0);
        idle(DISC + SS + 10);
        chk("re_disc", disconnect_o, 1);
        tog_step(0, 1'b0);
        idle(SS);
        step(cur_d, cur_s, 1'b0, 1'b1);
        chk("clr_edge_first", first_edge_o, 1);
        chk("clr_edge_disc", disconnect_o, 0);
        idle(3);
        chk("clr_edge_link", disconnect_o, 0);

        // alternate din/sin every 5 cycles for 2000 cycles
        step(cur_d, cur_s, 1'b0, 1'b1);
        act_lo = 0; disc_n = 0;
        for (int i = 0; i < 400; i++) begin
            tog_step(i % 2, 1'b0);
            for (int j = 0; j < 4; j++) begin
                idle(1);
                if (i > 0 && !activity_o) act_lo++;
                if (disconnect_o) disc_n++;
            end
        end
        idle(SS + 3);
        chk("alt_act_gap", act_lo, 0);
        chk("alt_disc", disc_n, 0);
`ifdef SPW_RX_ACT_EDGE_COUNT_EN
        chk("alt_cnt", edge_count_o, 400);
`endif
        // push the counter into saturation, then clear together with an edge
        for (int i = 0; i < 120; i++) begin
            tog_step(i % 2, 1'b0);
            idle(1);
        end
        idle(SS + 3);
`ifdef SPW_RX_ACT_EDGE_COUNT_EN
        chk("sat_cnt", edge_count_o, CMAX);
`endif
        tog_step(0, 1'b0);
        idle(SS);
        step(cur_d, cur_s, 1'b0, 1'b1);
`ifdef SPW_RX_ACT_EDGE_COUNT_EN
        chk("clr_edge_cnt", edge_count_o, 1);
`endif

        // randomized traffic: bursts, long silences, clears, occasional reset
        for (int seg = 0; seg < 60; seg++) begin
            int len;
            int rate;
            len = $urandom_range(30, 400);
            case ($urandom_range(0, 3))
                0:       rate = 0;
                1:       rate = 10;
                2:       rate = 200;
                default: rate = 600;
            endcase
            for (int i = 0; i < len; i++) begin
                bit c;
                c = ($urandom_range(0, 99) == 0);
                if ($urandom_range(0, 1999) == 0) begin
                    step(cur_d, cur_s, 1'b1, 1'b0);
                    continue;
                end
                if ($urandom_range(0, 999) < rate) begin
                    case ($urandom_range(0, 2))
                        0:       cur_d = ~cur_d;
                        1:       cur_s = ~cur_s;
                        default: begin cur_d = ~cur_d; cur_s = ~cur_s; end
                    endcase
                end
                step(cur_d, cur_s, 1'b0, c);
            end
        end

        // reset in the middle of a stretch aborts everything next cycle
        step(cur_d, cur_s, 1'b1, 1'b0);
        idle(10);
        tog_step(1, 1'b0);
        idle(300);
        chk("mid_act", activity_o, 1);
        step(cur_d, cur_s, 1'b1, 1'b0);
        chk("mid_rst_act", activity_o, 0);
        chk("mid_rst_first", first_edge_o, 0);
        chk("mid_rst_disc", disconnect_o, 0);
`ifdef SPW_RX_ACT_EDGE_COUNT_EN
        chk("mid_rst_cnt", edge_count_o, 0);
`endif
        step(cur_d, cur_s, 1'b1, 1'b0);
        idle(10);
        shot(40, fe_at, fe_n, act_n, dc_at);
        chk("post_rst_fe_lat", fe_at, SS + 2);
        chk("post_rst_fe_len", fe_n, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
